// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback, handshakes the shared memory port and raises traps.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             csr_we,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_LUI, C_AUIPC, C_OP, C_OPIMM, C_JAL, C_JALR, C_BRANCH, C_LOAD,
        C_STORE, C_FENCE, C_CSR, C_ECALL, C_EBREAK, C_ILLEGAL
    } cls_t;

    localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LIM =
        (MEM_TIMEOUT == 0) ? '0 : WCNT_W'(MEM_TIMEOUT - 1);

    function automatic cls_t classify(input logic [31:0] i);
        if (i[1:0] != 2'b11) return C_ILLEGAL;
        case (i[6:2])
            5'b01101: return C_LUI;
            5'b00101: return C_AUIPC;
            5'b01100: return C_OP;
            5'b00100: return C_OPIMM;
            5'b11011: return C_JAL;
            5'b11001: return C_JALR;
            5'b11000: return C_BRANCH;
            5'b00000: return C_LOAD;
            5'b01000: return C_STORE;
            5'b00011: return C_FENCE;
            5'b11100: begin
                if (i[14:12] != 3'b000) return C_CSR;
                return i[20] ? C_EBREAK : C_ECALL;
            end
            default:  return C_ILLEGAL;
        endcase
    endfunction

    state_t            state, state_n;
    logic [1:0]        cause, cause_n;
    logic [WCNT_W-1:0] wcnt;
    logic [CNT_W-1:0]  cnt;
    cls_t              cls;
    logic              lim_hit;

    logic       req_c, we_c, addr_c, irwe_c, pcwe_c, pcsrc_c, rfwe_c;
    logic [1:0] wbsel_c;
    logic       asel_c, bsel_c, csrwe_c, ret_c;

    assign cls     = classify(inst);
    // The limit cycle only traps when ready is still low; ready on it completes normally.
    assign lim_hit = (MEM_TIMEOUT != 0) && (wcnt == WCNT_LIM);

    always_comb begin
        state_n = state;
        cause_n = cause;
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = 1'b0;
        irwe_c  = 1'b0;
        pcwe_c  = 1'b0;
        pcsrc_c = 1'b0;
        rfwe_c  = 1'b0;
        wbsel_c = 2'd0;
        asel_c  = 1'b0;
        bsel_c  = 1'b0;
        csrwe_c = 1'b0;
        ret_c   = 1'b0;

        // ALU operand selects stay stable through EXEC, MEM and WB so the
        // combinational ALU result is valid as address and writeback data.
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            asel_c = (cls == C_AUIPC) || (cls == C_JAL);
            bsel_c = (cls == C_LUI) || (cls == C_AUIPC) || (cls == C_OPIMM) ||
                     (cls == C_JAL) || (cls == C_JALR) || (cls == C_LOAD) ||
                     (cls == C_STORE);
        end

        unique case (state)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    irwe_c  = 1'b1;
                    state_n = S_DECODE;
                end else if (lim_hit) begin
                    state_n = S_TRAP;
                    cause_n = 2'd3;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_ILLEGAL: begin state_n = S_TRAP; cause_n = 2'd0; end
                    C_ECALL:   begin state_n = S_TRAP; cause_n = 2'd1; end
                    C_EBREAK:  begin state_n = S_TRAP; cause_n = 2'd2; end
                    default:   state_n = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    C_BRANCH: begin
                        pcwe_c  = 1'b1;
                        pcsrc_c = branch_taken;
                        ret_c   = 1'b1;
                        state_n = S_FETCH;
                    end
                    C_FENCE: begin
                        pcwe_c  = 1'b1;
                        ret_c   = 1'b1;
                        state_n = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_n = S_MEM;
                    default:         state_n = S_WB;
                endcase
            end
            S_MEM: begin
                req_c  = 1'b1;
                addr_c = 1'b1;
                we_c   = (cls == C_STORE);
                if (mem_ready) begin
                    if (cls == C_STORE) begin
                        pcwe_c  = 1'b1;
                        ret_c   = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (lim_hit) begin
                    state_n = S_TRAP;
                    cause_n = 2'd3;
                end
            end
            S_WB: begin
                rfwe_c  = 1'b1;
                pcwe_c  = 1'b1;
                ret_c   = 1'b1;
                state_n = S_FETCH;
                case (cls)
                    C_JAL, C_JALR: begin wbsel_c = 2'd2; pcsrc_c = 1'b1; end
                    C_LOAD:        wbsel_c = 2'd1;
                    C_CSR:         begin wbsel_c = 2'd3; csrwe_c = 1'b1; end
                    default:       wbsel_c = 2'd0;
                endcase
            end
            S_TRAP: state_n = S_TRAP;
            default: state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            cause <= 2'd0;
            wcnt  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cause <= cause_n;
            if (state_n != state)
                wcnt <= '0;
            else if (req_c && !mem_ready)
                wcnt <= wcnt + WCNT_W'(1);
            if (ret_c)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Everything is forced low while reset is held, including in-flight strobes.
    assign mem_req    = req_c   & ~reset;
    assign mem_we     = we_c    & ~reset;
    assign addr_sel   = addr_c  & ~reset;
    assign ir_we      = irwe_c  & ~reset;
    assign pc_we      = pcwe_c  & ~reset;
    assign pc_src     = pcsrc_c & ~reset;
    assign rf_we      = rfwe_c  & ~reset;
    assign wb_sel     = reset ? 2'd0 : wbsel_c;
    assign alu_a_sel  = asel_c  & ~reset;
    assign alu_b_sel  = bsel_c  & ~reset;
    assign csr_we     = csrwe_c & ~reset;
    assign retire     = ret_c   & ~reset;
    assign instret    = reset ? '0 : cnt;
    assign trap       = (state == S_TRAP) & ~reset;
    assign trap_cause = reset ? 2'd0 : cause;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table for the instruction
// classes, plus hand sequences for traps, timeouts, counter wrap and reset.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst = 32'h0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, rf_we;
    logic [1:0]  wb_sel;
    logic        alu_a_sel, alu_b_sel, csr_we, retire, trap;
    logic [3:0]  instret;
    logic [1:0]  trap_cause;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .inst(inst), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .rf_we(rf_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .csr_we(csr_we), .retire(retire),
        .instret(instret), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    // {mem_req mem_we addr_sel ir_we | pc_we pc_src rf_we | wb_sel | a_sel b_sel csr_we retire | trap cause}
    logic [15:0] got;
    assign got = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, rf_we, wb_sel,
                  alu_a_sel, alu_b_sel, csr_we, retire, trap, trap_cause};

    localparam logic [15:0] FW  = 16'b1000_000_00_0000_000;
    localparam logic [15:0] FR  = 16'b1001_000_00_0000_000;
    localparam logic [15:0] NOP = 16'b0000_000_00_0000_000;
    localparam logic [15:0] TR0 = 16'b0000_000_00_0000_100;
    localparam logic [15:0] TR1 = 16'b0000_000_00_0000_101;
    localparam logic [15:0] TR2 = 16'b0000_000_00_0000_110;
    localparam logic [15:0] TR3 = 16'b0000_000_00_0000_111;

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_BEQ   = 32'h00000463;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_AUIPC = 32'h00001097;
    localparam logic [31:0] I_CSRRW = 32'h30011073;
    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_FENCE = 32'h0FF0000F;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_LUI   = 32'h123450B7;

    typedef struct {
        logic [31:0] inst;
        logic        rdy;
        logic        bt;
        logic [15:0] exp;
        logic [3:0]  icnt;
        string       name;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic [31:0] i, input logic r, input logic b,
                       input logic [15:0] e, input logic [3:0] c, input string nm);
        vec_t v;
        v.inst = i; v.rdy = r; v.bt = b; v.exp = e; v.icnt = c; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [15:0] e, input logic [3:0] c);
        n_chk++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: outputs got %b expected %b", nm, got, e);
        end
        n_chk++;
        if (instret !== c) begin
            n_fail++;
            $display("FAIL %s: instret got %0d expected %0d", nm, instret, c);
        end
    endtask

    // One clock cycle with reset released: drive at negedge, sample 1ns later.
    task automatic cyc(input logic [31:0] i, input logic r, input logic b,
                       input logic [15:0] e, input logic [3:0] c, input string nm);
        @(negedge clk);
        reset = 1'b0; inst = i; mem_ready = r; branch_taken = b;
        #1;
        check(nm, e, c);
    endtask

    task automatic rst_cyc(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            reset = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1;
            #1;
            check(nm, NOP, 4'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        add(I_ADDI, 1, 0, FR, 0, "addi F");
        add(I_ADDI, 1, 0, NOP, 0, "addi D");
        add(I_ADDI, 1, 0, 16'b0000_000_00_0100_000, 0, "addi E");
        add(I_ADDI, 1, 0, 16'b0000_101_00_0101_000, 0, "addi WB");
        add(I_LW, 1, 0, FR, 1, "lw F");
        add(I_LW, 1, 0, NOP, 1, "lw D");
        add(I_LW, 1, 0, 16'b0000_000_00_0100_000, 1, "lw E");
        for (int k = 0; k < 3; k++)
            add(I_LW, 0, 0, 16'b1010_000_00_0100_000, 1, "lw M wait");
        add(I_LW, 1, 0, 16'b1010_000_00_0100_000, 1, "lw M ready");
        add(I_LW, 1, 0, 16'b0000_101_01_0101_000, 1, "lw WB");
        add(I_SW, 1, 0, FR, 2, "sw F");
        add(I_SW, 1, 0, NOP, 2, "sw D");
        add(I_SW, 1, 0, 16'b0000_000_00_0100_000, 2, "sw E");
        add(I_SW, 0, 0, 16'b1110_000_00_0100_000, 2, "sw M wait");
        add(I_SW, 1, 0, 16'b1110_100_00_0101_000, 2, "sw M ready");
        add(I_BEQ, 1, 1, FR, 3, "beq-t F");
        add(I_BEQ, 1, 1, NOP, 3, "beq-t D");
        add(I_BEQ, 1, 1, 16'b0000_110_00_0001_000, 3, "beq-t E");
        add(I_BEQ, 1, 0, FR, 4, "beq-nt F");
        add(I_BEQ, 1, 0, NOP, 4, "beq-nt D");
        add(I_BEQ, 1, 0, 16'b0000_100_00_0001_000, 4, "beq-nt E");
        add(I_JAL, 1, 0, FR, 5, "jal F");
        add(I_JAL, 1, 0, NOP, 5, "jal D");
        add(I_JAL, 1, 0, 16'b0000_000_00_1100_000, 5, "jal E");
        add(I_JAL, 1, 0, 16'b0000_111_10_1101_000, 5, "jal WB");
        add(I_AUIPC, 1, 0, FR, 6, "auipc F");
        add(I_AUIPC, 1, 0, NOP, 6, "auipc D");
        add(I_AUIPC, 1, 0, 16'b0000_000_00_1100_000, 6, "auipc E");
        add(I_AUIPC, 1, 0, 16'b0000_101_00_1101_000, 6, "auipc WB");
        add(I_CSRRW, 1, 0, FR, 7, "csr F");
        add(I_CSRRW, 1, 0, NOP, 7, "csr D");
        add(I_CSRRW, 1, 0, NOP, 7, "csr E");
        add(I_CSRRW, 1, 0, 16'b0000_101_11_0011_000, 7, "csr WB");
        add(I_ADD, 1, 0, FR, 8, "add F");
        add(I_ADD, 1, 0, NOP, 8, "add D");
        add(I_ADD, 1, 0, NOP, 8, "add E");
        add(I_ADD, 1, 0, 16'b0000_101_00_0001_000, 8, "add WB");
        add(I_FENCE, 0, 0, FW, 9, "fence F wait");
        add(I_FENCE, 1, 0, FR, 9, "fence F");
        add(I_FENCE, 1, 0, NOP, 9, "fence D");
        add(I_FENCE, 1, 0, 16'b0000_100_00_0001_000, 9, "fence E");
        add(I_JALR, 1, 0, FR, 10, "jalr F");
        add(I_JALR, 1, 0, NOP, 10, "jalr D");
        add(I_JALR, 1, 0, 16'b0000_000_00_0100_000, 10, "jalr E");
        add(I_JALR, 1, 0, 16'b0000_111_10_0101_000, 10, "jalr WB");
        add(I_LUI, 1, 0, FR, 11, "lui F");
        add(I_LUI, 1, 0, NOP, 11, "lui D");
        add(I_LUI, 1, 0, 16'b0000_000_00_0100_000, 11, "lui E");
        add(I_LUI, 1, 0, 16'b0000_101_00_0101_000, 11, "lui WB");

        rst_cyc(2, "reset");
        foreach (tbl[n])
            cyc(tbl[n].inst, tbl[n].rdy, tbl[n].bt, tbl[n].exp, tbl[n].icnt, tbl[n].name);

        // instret wraps modulo 16: 12 + 4 fences -> 0
        for (int k = 0; k < 4; k++) begin
            cyc(I_FENCE, 1, 0, FR, 4'(12 + k), "wrap F");
            cyc(I_FENCE, 1, 0, NOP, 4'(12 + k), "wrap D");
            cyc(I_FENCE, 1, 0, 16'b0000_100_00_0001_000, 4'(12 + k), "wrap E");
        end

        // ECALL: trap held, no retire, instret frozen
        cyc(32'h00000073, 1, 0, FR, 0, "ecall F");
        cyc(32'h00000073, 1, 0, NOP, 0, "ecall D");
        cyc(32'h00000073, 1, 0, TR1, 0, "ecall trap");
        cyc(32'h00000073, 0, 1, TR1, 0, "ecall hold");
        cyc(32'h00000073, 1, 0, TR1, 0, "ecall hold2");
        rst_cyc(2, "reset after ecall");

        cyc(32'h00000000, 1, 0, FR, 0, "illegal F");
        cyc(32'h00000000, 1, 0, NOP, 0, "illegal D");
        cyc(32'h00000000, 1, 0, TR0, 0, "illegal trap");
        cyc(32'h00000000, 0, 0, TR0, 0, "illegal hold");
        rst_cyc(1, "reset after illegal");

        cyc(32'h00100073, 1, 0, FR, 0, "ebreak F");
        cyc(32'h00100073, 1, 0, NOP, 0, "ebreak D");
        cyc(32'h00100073, 1, 0, TR2, 0, "ebreak trap");
        cyc(32'h00100073, 1, 0, TR2, 0, "ebreak hold");
        rst_cyc(1, "reset after ebreak");

        cyc(32'h0000007F, 1, 0, FR, 0, "badop F");
        cyc(32'h0000007F, 1, 0, NOP, 0, "badop D");
        cyc(32'h0000007F, 1, 0, TR0, 0, "badop trap");
        rst_cyc(1, "reset after badop");

        // Fetch timeout: 4 wait cycles then trap cause 3
        for (int k = 0; k < 4; k++)
            cyc(I_FENCE, 0, 0, FW, 0, "fetch timeout wait");
        cyc(I_FENCE, 1, 0, TR3, 0, "fetch timeout trap");
        cyc(I_FENCE, 1, 0, TR3, 0, "fetch timeout hold");
        rst_cyc(1, "reset after fetch timeout");

        // Ready on the limit cycle wins
        for (int k = 0; k < 3; k++)
            cyc(I_FENCE, 0, 0, FW, 0, "fetch late wait");
        cyc(I_FENCE, 1, 0, FR, 0, "fetch late ready");
        cyc(I_FENCE, 1, 0, NOP, 0, "fetch late D");
        cyc(I_FENCE, 1, 0, 16'b0000_100_00_0001_000, 0, "fetch late E");

        // Memory-stage timeout on a load
        cyc(I_LW, 1, 0, FR, 1, "mem timeout F");
        cyc(I_LW, 1, 0, NOP, 1, "mem timeout D");
        cyc(I_LW, 1, 0, 16'b0000_000_00_0100_000, 1, "mem timeout E");
        for (int k = 0; k < 4; k++)
            cyc(I_LW, 0, 0, 16'b1010_000_00_0100_000, 1, "mem timeout wait");
        cyc(I_LW, 1, 0, TR3, 1, "mem timeout trap");
        rst_cyc(1, "reset after mem timeout");

        // Reset in the middle of a store aborts it, then fetch restarts
        cyc(I_SW, 1, 0, FR, 0, "abort F");
        cyc(I_SW, 1, 0, NOP, 0, "abort D");
        cyc(I_SW, 1, 0, 16'b0000_000_00_0100_000, 0, "abort E");
        cyc(I_SW, 0, 0, 16'b1110_000_00_0100_000, 0, "abort M");
        rst_cyc(1, "abort reset");
        cyc(I_SW, 1, 0, FR, 0, "abort refetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback for every instruction. It drives the shared memory port with a req/ready handshake, and drives the datapath selects and write enables consumed by the PC, IR, register file, ALU, immediate builder and CSR unit. It also detects illegal and system instructions and memory timeouts, and counts retired instructions.

Parameters:
MEM_TIMEOUT, 255, wait cycles allowed per memory transaction before trap; 0 disables timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
inst  in  32  IR contents (valid from DECODE onward)
mem_ready  in  1  memory completes transaction this cycle
branch_taken  in  1  ALU compare result, valid in EXEC
mem_req  out  1  memory request
mem_we  out  1  store request (with mem_req)
addr_sel  out  1  0=PC, 1=ALU result as memory address
ir_we  out  1  latch memory data into IR
pc_we  out  1  update PC
pc_src  out  1  0=PC+4, 1=ALU target
rf_we  out  1  register file write
wb_sel  out  2  0=ALU, 1=MEM, 2=PC+4, 3=CSR
alu_a_sel  out  1  0=rs1, 1=PC
alu_b_sel  out  1  0=rs2, 1=imm
csr_we  out  1  CSR write strobe
retire  out  1  one-cycle pulse per retired instruction
instret  out  CNT_W  retired instruction count
trap  out  1  core halted on trap
trap_cause  out  2  0=illegal, 1=ecall, 2=ebreak, 3=mem timeout

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are decoded from state, inst and mem_ready. ir_we and MEM-exit depend on mem_ready.
- Reset: while reset is high, all outputs are 0, instret=0, trap_cause=0 and the wait counter is 0. The state is FETCH on the first cycle after release, so mem_req=1 on that cycle. Reset mid-transaction aborts it; no retire occurs.
- FETCH: mem_req=1, addr_sel=0. Stay in FETCH while !mem_ready. On mem_ready: ir_we=1, go to DECODE.
- DECODE: 1 cycle, no strobes. Classify on inst[6:2]; inst[1:0]!=2'b11 is illegal.
- Class LUI 01101, AUIPC 00101, OP 01100, OP-IMM 00100:
  - EXEC sets alu_a_sel=1 only for AUIPC, and alu_b_sel=1 for all except OP.
  - WB: rf_we=1, wb_sel=0, pc_we=1, pc_src=0.
- Class JAL 11011 / JALR 11001:
  - EXEC: a_sel=PC for JAL, rs1 for JALR; b_sel=imm.
  - WB: rf_we=1, wb_sel=2, pc_we=1, pc_src=1.
- Class BRANCH 11000:
  - EXEC: pc_we=1, pc_src=branch_taken, retire=1, then FETCH. Target supplied by datapath.
- Class LOAD 00000:
  - EXEC computes the address with b_sel=imm.
  - MEM: mem_req=1, addr_sel=1, wait for mem_ready.
  - WB: rf_we=1, wb_sel=1, pc_we=1.
- Class STORE 01000:
  - MEM: mem_req=1, mem_we=1, addr_sel=1.
  - On mem_ready: pc_we=1, pc_src=0, retire=1, go to FETCH.
- Class MISC-MEM 00011 (FENCE): treated as nop. EXEC: pc_we=1, pc_src=0, retire=1, then FETCH.
- Class SYSTEM 11100:
  - funct3!=000: CSR op. WB: rf_we=1, wb_sel=3, csr_we=1, pc_we=1.
  - funct3==000: inst[20]=0 gives cause 1, else cause 2; go to TRAP from DECODE.
- Any other opcode: DECODE -> TRAP, cause 0.
- retire pulses in the final state of each instruction (WB, or the EXEC/MEM exit noted above). instret increments on the same cycle and wraps modulo 2^CNT_W.
- Wait counter:
  - Cleared on entry to FETCH/MEM; increments each cycle with mem_req && !mem_ready.
  - When MEM_TIMEOUT!=0 and count reaches MEM_TIMEOUT with mem_ready still low: next state TRAP, cause 3.
  - mem_ready on the same cycle as reaching the limit wins and completes normally.
- TRAP: trap=1, all strobes 0, and trap_cause holds. The state is held until reset. No retire for the trapping instruction.
- Latency with mem_ready=1 every cycle: ALU/jump/CSR 4 cycles, load 5, store 4, branch/fence 3.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready tied 1 -> ir_we cycle 1; WB on cycle 4 with rf_we=1, wb_sel=0, alu_b_sel=1, pc_we=1; retire=1; instret 0->1.
- LW x2,0(x1) (0x0000A103), ready delayed 3 cycles in MEM -> mem_req=1, addr_sel=1 for 4 MEM cycles; then WB wb_sel=1, rf_we=1; total 8 cycles.
- SW x2,4(x1) (0x0020A223) -> MEM mem_we=1, mem_req=1; on ready pc_we=1, retire=1, rf_we never 1; back to FETCH.
- BEQ x0,x0,8 (0x00000463) with branch_taken=1, then =0 -> EXEC pc_we=1 with pc_src=1, then pc_src=0; 3 cycles each.
- ECALL 0x00000073 -> trap=1, cause=1; 0x00000000 -> cause=0; 0x00100073 -> cause=2. In all cases no retire and state held; reset releases to FETCH with mem_req=1.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> trap=1, cause=3 after 4 wait cycles. Repeat with ready arriving on cycle 4 -> normal completion, no trap.
